// File: rtl/branch_resolver.sv
// Resolves EX-stage branches/jumps from ALU flags and redirects fetch one cycle after acceptance.
// Wrong-path squash: flush stays high FLUSH_CYCLES non-stalled cycles; stall freezes all state.
module branch_resolver #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic             is_jump,
  input  logic [2:0]       br_funct3,
  input  logic             Z,
  input  logic             N,
  input  logic             C,
  input  logic             V,
  input  logic [31:0]      target,
  input  logic             stall,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] notaken_cnt,
  output logic             illegal
);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_fcnt;
  logic [3:0] w_fcnt_nxt;

  logic w_cond;
  logic w_f3_illegal;
  logic w_accept;
  logic w_taken;
  logic w_notaken;
  logic w_ill_seen;

  // C is the unsigned borrow of A-B, so LTU is simply C.
  always_comb begin
    w_cond       = 1'b0;
    w_f3_illegal = 1'b0;
    case (br_funct3)
      3'b000:  w_cond = Z;
      3'b001:  w_cond = ~Z;
      3'b100:  w_cond = N ^ V;
      3'b101:  w_cond = ~(N ^ V);
      3'b110:  w_cond = C;
      3'b111:  w_cond = ~C;
      default: w_f3_illegal = 1'b1;
    endcase
  end

  assign w_accept   = (r_state == S_IDLE) & br_valid & ~stall;
  assign w_taken    = w_accept & (is_jump | (w_cond & ~w_f3_illegal));
  assign w_notaken  = w_accept & ~is_jump & ~w_f3_illegal & ~w_cond;
  assign w_ill_seen = w_accept & ~is_jump & w_f3_illegal;

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      S_IDLE: begin
        if (w_taken) begin
          w_state_nxt = S_FLUSH;
          w_fcnt_nxt  = FLUSH_LOAD;
        end
      end
      S_FLUSH: begin
        if (!stall) begin
          if (r_fcnt != 4'd0) begin
            w_fcnt_nxt = r_fcnt - 4'd1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_fcnt_nxt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_fcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect    <= 1'b0;
      redirect_pc <= 32'd0;
      taken_cnt   <= '0;
      notaken_cnt <= '0;
      illegal     <= 1'b0;
    end else begin
      redirect <= w_taken;
      if (w_taken) begin
        redirect_pc <= target;
      end
      // Counters stick at all-ones rather than wrapping.
      if (w_taken && (taken_cnt != {CNT_W{1'b1}})) begin
        taken_cnt <= taken_cnt + 1'b1;
      end
      if (w_notaken && (notaken_cnt != {CNT_W{1'b1}})) begin
        notaken_cnt <= notaken_cnt + 1'b1;
      end
      if (w_ill_seen) begin
        illegal <= 1'b1;
      end
    end
  end

  assign flush = (r_state == S_FLUSH);
  assign busy  = (r_state == S_FLUSH);

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Consumes the ALU's Z/N/C/V flags and computed target in the EX stage, and decides conditional-branch and jump outcomes.
- Drives the fetch redirect and a timed pipeline flush for squashing wrong-path instructions.
- Keeps saturating taken/not-taken statistics counters.
- Sits between the EX stage (ALU output side) and the IF/ID control logic.

Parameters:
FLUSH_CYCLES, 2, cycles flush stays asserted after a taken branch (legal range 1..15)
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
br_valid  input  1  EX stage holds a conditional branch this cycle
is_jump  input  1  EX stage holds JAL/JALR (unconditional, always taken); qualified by br_valid
br_funct3  input  3  condition: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU
Z, N, C, V  input  1 each  ALU flags from the compare subtraction A-B; C=1 means unsigned borrow (A<B)
target  input  32  branch/jump target computed by ALU
stall  input  1  pipeline stall; freezes this block's state
redirect  output  1  one-cycle pulse: fetch must load redirect_pc
redirect_pc  output  32  registered target
flush  output  1  squash IF/ID while high
busy  output  1  high in FLUSH state
taken_cnt  output  CNT_W  saturating count of taken resolutions
notaken_cnt  output  CNT_W  saturating count of not-taken conditional branches
illegal  output  1  sticky: a reserved funct3 (010/011) was seen

Behaviour:
- Reset (asynchronous, any state): all outputs 0, state IDLE, flush counter 0, redirect_pc 0.
- Condition decode is combinational; the decision is registered:
  - EQ=Z, NE=~Z
  - LT=N^V, GE=~(N^V)
  - LTU=C, GEU=~C
  - is_jump=1 forces taken, and funct3 is ignored.
- Accept condition: state IDLE, br_valid=1 and stall=0, sampled at edge T.
- Taken at T, cycle T+1:
  - redirect=1 for exactly one cycle; redirect_pc=target sampled at T.
  - flush=1, busy=1, state FLUSH, counter loaded with FLUSH_CYCLES-1.
  - taken_cnt increments.
- FLUSH state:
  - Each non-stalled cycle with counter>0 decrements the counter.
  - In a non-stalled cycle with counter==0, the state returns to IDLE at the next edge and flush/busy drop.
  - flush is therefore high for exactly FLUSH_CYCLES cycles when no stall occurs.
  - With stall=1, the counter freezes and flush stays high, extending the window by the stall length.
- Not taken at T: no redirect, no flush; notaken_cnt increments at T+1; state stays IDLE (back-to-back branches accepted every cycle).
- Illegal funct3 with is_jump=0: treated as not taken, not counted; illegal is set at T+1 and held until reset.
- br_valid is ignored whenever state is FLUSH (those instructions are wrong-path) or stall=1.
- redirect_pc holds its last value between redirects.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-FLUSH: flush and redirect drop immediately (asynchronously); counters and illegal clear.
- Latency: decision to redirect is one cycle. No combinational path from any input to any output.

Test Plan:
- BEQ taken: funct3=000, Z=1, target=0x0000_0040, FLUSH_CYCLES=2 -> redirect pulse at T+1, redirect_pc=0x40, flush high T+1..T+2, taken_cnt=1.
- Signed/unsigned decode:
  - LT with N=1,V=0 -> taken.
  - LT with N=1,V=1 -> not taken, notaken_cnt=1.
  - LTU with C=1 -> taken.
  - GEU with C=1 -> not taken.
- Wrong-path and back-to-back:
  - br_valid=1 (Z=1, funct3=000) during both flush cycles -> ignored, taken_cnt unchanged.
  - Three consecutive not-taken branches in IDLE -> notaken_cnt=3, no flush.
- Stall in FLUSH: taken JAL (is_jump=1, funct3=010) -> illegal stays 0; stall held 3 cycles at T+1 -> flush high 5 cycles total; stall=1 at accept edge -> branch ignored.
- Saturation and illegal:
  - CNT_W=4, 17 taken jumps -> taken_cnt=15.
  - funct3=011, br_valid=1 -> illegal=1 and stays 1, counters unchanged.
- Reset mid-flush: assert reset at T+1 between edges -> flush, busy, redirect_pc, counters = 0 immediately; next branch after deassert behaves as from IDLE.
